// File: rtl/lane_judge.sv
// lane_judge: hit/miss judge for one lane of a falling-block rhythm game.
//
// Watches the block height of this lane and the player's key. It makes exactly
// one judgement per block. A key press while the block is inside
// [WIN_LO, WIN_HI] is a hit. A block that leaves the window or respawns
// without a press is a miss. The module also keeps score, the current combo
// and the best combo.
//
// Ports
//   clk             in   rising-edge clock; the same tick that advances block_h
//   rst             in   synchronous active-high reset
//   restart         in   synchronous clear; same effect as rst
//   stop_or_endgame in   freeze: FSM, prev_h and counters hold, pulses are 0
//   block_h[9:0]    in   block height from the block generator
//   key_in          in   raw asynchronous key
//   hit             out  one-cycle pulse, successful press
//   miss            out  one-cycle pulse, missed block
//   perfect         out  one-cycle pulse coincident with hit (optional)
//   block_clear     out  level, high from a hit until the next new block
//   score[9:0]      out  points, saturating at SCORE_MAX
//   combo[6:0]      out  consecutive hits, saturating at 127
//   max_combo[6:0]  out  best combo since reset
//
// Build option: define JUDGE_PERFECT_EN to enable the perfect sub-window
// [585, 615]. A perfect hit scores 2 points instead of 1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_WAIT   | block above the window, or a new block not yet in the window
// S_WINDOW | block inside the window, waiting for a press
// S_DONE   | this block is judged; waiting for the generator to respawn

module lane_judge #(
    parameter int unsigned WIN_LO    = 540,
    parameter int unsigned WIN_HI    = 660,
    parameter int unsigned SCORE_MAX = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       stop_or_endgame,
    input  logic [9:0] block_h,
    input  logic       key_in,
    output logic       hit,
    output logic       miss,
    output logic       perfect,
    output logic       block_clear,
    output logic [9:0] score,
    output logic [6:0] combo,
    output logic [6:0] max_combo
);

    typedef enum logic [1:0] {S_WAIT, S_WINDOW, S_DONE} state_t;

    localparam logic [9:0]  LP_WIN_LO    = 10'(WIN_LO);
    localparam logic [9:0]  LP_WIN_HI    = 10'(WIN_HI);
    localparam logic [10:0] LP_SCORE_MAX = 11'(SCORE_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1, r_sync2, r_key_d;
    logic [9:0]  r_prev_h;
    logic        r_hit, r_miss, r_perfect, r_block_clear;
    logic [9:0]  r_score;
    logic [6:0]  r_combo, r_max_combo;

    logic        w_clr;
    logic        w_in_win, w_past_win, w_new_blk, w_key_edge;
    logic        w_hit, w_miss, w_perf, w_unclear;
    logic [10:0] w_score_sum;
    logic [9:0]  w_score_sat;
    logic [6:0]  w_combo_inc;

    assign w_clr      = rst | restart;
    assign w_in_win   = (block_h >= LP_WIN_LO) && (block_h <= LP_WIN_HI);
    assign w_past_win = block_h > LP_WIN_HI;
    assign w_new_blk  = block_h < r_prev_h;
    assign w_key_edge = r_sync2 & ~r_key_d;

    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_unclear   = 1'b0;
        if (!stop_or_endgame) begin
            case (r_state)
                S_WAIT: begin
                    if (!w_new_blk && w_in_win)
                        w_state_nxt = S_WINDOW;
                end
                S_WINDOW: begin
                    // A respawn beats a same-cycle press: the old block is gone.
                    if (w_new_blk) begin
                        w_miss      = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else if (w_key_edge && w_in_win) begin
                        w_hit       = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_past_win) begin
                        w_miss      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_new_blk) begin
                        w_unclear   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
                default: w_state_nxt = S_WAIT;
            endcase
        end
    end

`ifdef JUDGE_PERFECT_EN
    localparam logic [9:0] LP_PERF_LO = 10'd585;
    localparam logic [9:0] LP_PERF_HI = 10'd615;
    assign w_perf = w_hit && (block_h >= LP_PERF_LO) && (block_h <= LP_PERF_HI);
`else
    assign w_perf = 1'b0;
`endif

    assign w_score_sum = {1'b0, r_score} + (w_perf ? 11'd2 : 11'd1);
    assign w_score_sat = (w_score_sum > LP_SCORE_MAX) ? LP_SCORE_MAX[9:0] : w_score_sum[9:0];
    assign w_combo_inc = (r_combo == 7'd127) ? r_combo : r_combo + 7'd1;

    always_ff @(posedge clk) begin
        if (w_clr)
            r_state <= S_WAIT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_key_d       <= 1'b0;
            r_prev_h      <= 10'd0;
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;
            r_perfect     <= 1'b0;
            r_block_clear <= 1'b0;
            r_score       <= 10'd0;
            r_combo       <= 7'd0;
            r_max_combo   <= 7'd0;
        end else begin
            // The synchronizer and edge flop run even while frozen, so a press
            // made during the freeze is used up and does not count afterwards.
            r_sync1   <= key_in;
            r_sync2   <= r_sync1;
            r_key_d   <= r_sync2;
            r_hit     <= w_hit;
            r_miss    <= w_miss;
            r_perfect <= w_perf;
            if (!stop_or_endgame)
                r_prev_h <= block_h;
            if (w_hit) begin
                r_score       <= w_score_sat;
                r_combo       <= w_combo_inc;
                r_block_clear <= 1'b1;
                if (w_combo_inc > r_max_combo)
                    r_max_combo <= w_combo_inc;
            end else if (w_miss) begin
                r_combo <= 7'd0;
            end
            if (w_unclear)
                r_block_clear <= 1'b0;
        end
    end

    assign hit         = r_hit;
    assign miss        = r_miss;
    assign perfect     = r_perfect;
    assign block_clear = r_block_clear;
    assign score       = r_score;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;

endmodule

// File: tb/tb_lane_judge.sv
// Directed bench for lane_judge.
// A table of single-cycle vectors covers the basic judge flow. Hand-written
// ramps cover the multi-cycle corners: respawn, saturation, freeze and restart.
// Outputs are sampled 1 ns after each rising edge.

module tb_lane_judge;

`ifdef JUDGE_PERFECT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic       stop_or_endgame = 1'b0;
    logic [9:0] block_h = 10'd0;
    logic       key_in = 1'b0;
    logic       hit, miss, perfect, block_clear;
    logic [9:0] score;
    logic [6:0] combo, max_combo;

    int n_checks = 0;
    int n_errors = 0;
    int exp_score, exp_combo, exp_max;

    lane_judge dut (
        .clk             (clk),
        .rst             (rst),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .block_h         (block_h),
        .key_in          (key_in),
        .hit             (hit),
        .miss            (miss),
        .perfect         (perfect),
        .block_clear     (block_clear),
        .score           (score),
        .combo           (combo),
        .max_combo       (max_combo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int k;
        int e_hit;
        int e_miss;
        int e_clr;
        int e_score;
        int e_combo;
        int e_max;
    } vec_t;

    vec_t tbl [17];

    task automatic step(input int h, input int k);
        block_h = 10'(h);
        key_in  = (k != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, " score"}, int'(score), exp_score);
        chk({nm, " combo"}, int'(combo), exp_combo);
        chk({nm, " max_combo"}, int'(max_combo), exp_max);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step(0, 0);
        restart = 1'b0;
        exp_score = 0;
        exp_combo = 0;
        exp_max   = 0;
    endtask

    // One block: respawn low, enter the window at hh, key rises at hh and
    // the edge is judged two samples later at hh+2.
    task automatic press_block(input int hh);
        step(100, 0);
        step(110, 0);
        step(hh, 1);
        step(hh + 1, 1);
        step(hh + 2, 1);
    endtask

    initial begin
        tbl[0]  = '{500, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{510, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{520, 1, 0, 0, 0, 0, 0, 0};  // edge in WAIT: ignored
        tbl[3]  = '{530, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{560, 0, 0, 0, 0, 0, 0, 0};  // enter WINDOW
        tbl[5]  = '{560, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{570, 1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{580, 1, 1, 0, 1, 1, 1, 1};  // hit
        tbl[8]  = '{600, 1, 0, 0, 1, 1, 1, 1};
        tbl[9]  = '{700, 0, 0, 0, 1, 1, 1, 1};
        tbl[10] = '{100, 0, 0, 0, 0, 1, 1, 1};  // new block clears block_clear
        tbl[11] = '{550, 0, 0, 0, 0, 1, 1, 1};
        tbl[12] = '{620, 0, 0, 0, 0, 1, 1, 1};
        tbl[13] = '{661, 0, 0, 1, 0, 1, 0, 1};  // leaves window: miss
        tbl[14] = '{720, 0, 0, 0, 0, 1, 0, 1};
        tbl[15] = '{720, 0, 0, 0, 0, 1, 0, 1};
        tbl[16] = '{130, 0, 0, 0, 0, 1, 0, 1};

        // reset state
        rst = 1'b1;
        step(600, 1);
        step(600, 1);
        chk("rst hit", int'(hit), 0);
        chk("rst miss", int'(miss), 0);
        chk("rst perfect", int'(perfect), 0);
        chk("rst block_clear", int'(block_clear), 0);
        chk("rst score", int'(score), 0);
        chk("rst combo", int'(combo), 0);
        chk("rst max_combo", int'(max_combo), 0);
        rst = 1'b0;
        step(0, 0);

        // table vectors: early press ignored, normal hit, window-exit miss
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].h, tbl[i].k);
            chk($sformatf("tbl[%0d] hit", i), int'(hit), tbl[i].e_hit);
            chk($sformatf("tbl[%0d] miss", i), int'(miss), tbl[i].e_miss);
            chk($sformatf("tbl[%0d] perfect", i), int'(perfect), 0);
            chk($sformatf("tbl[%0d] block_clear", i), int'(block_clear), tbl[i].e_clr);
            chk($sformatf("tbl[%0d] score", i), int'(score), tbl[i].e_score);
            chk($sformatf("tbl[%0d] combo", i), int'(combo), tbl[i].e_combo);
            chk($sformatf("tbl[%0d] max_combo", i), int'(max_combo), tbl[i].e_max);
        end

        // ramp 500..700, key rises at 598, judged at 600
        do_restart();
        for (int h = 500; h <= 700; h++) begin
            step(h, int'(h >= 598));
            chk($sformatf("rampA h=%0d hit", h), int'(hit), int'(h == 600));
            chk($sformatf("rampA h=%0d perfect", h), int'(perfect), int'(h == 600) * PERF);
            chk($sformatf("rampA h=%0d miss", h), int'(miss), 0);
            if (h >= 600)
                chk($sformatf("rampA h=%0d block_clear", h), int'(block_clear), 1);
        end
        exp_score = 1 + PERF;
        exp_combo = 1;
        exp_max   = 1;
        chk_counts("rampA");

        // next block ramps to 720 unpressed: miss only at 661, none while held
        for (int h = 500; h <= 720; h++) begin
            step(h, 0);
            if (h == 500)
                chk("rampB new block_clear", int'(block_clear), 0);
            chk($sformatf("rampB h=%0d miss", h), int'(miss), int'(h == 661));
            chk($sformatf("rampB h=%0d hit", h), int'(hit), 0);
        end
        for (int n = 0; n < 20; n++) begin
            step(720, 0);
            chk("rampB hold miss", int'(miss), 0);
        end
        exp_combo = 0;
        chk_counts("rampB");

        // respawn while in WINDOW: miss, then a normal hit on the next block
        for (int h = 500; h <= 600; h++) begin
            step(h, 0);
            chk($sformatf("rampC h=%0d miss", h), int'(miss), 0);
        end
        step(120, 0);
        chk("rampC respawn miss", int'(miss), 1);
        chk("rampC respawn hit", int'(hit), 0);
        for (int h = 121; h <= 700; h++) begin
            step(h, int'(h >= 598));
            chk($sformatf("rampC2 h=%0d hit", h), int'(hit), int'(h == 600));
            chk($sformatf("rampC2 h=%0d miss", h), int'(miss), 0);
        end
        exp_score += 1 + PERF;
        exp_combo = 1;
        chk_counts("rampC2");

        // key edge landing exactly at WIN_HI counts as a hit
        for (int h = 500; h <= 700; h++) begin
            step(h, int'(h >= 658));
            chk($sformatf("edge660 h=%0d hit", h), int'(hit), int'(h == 660));
            chk($sformatf("edge660 h=%0d miss", h), int'(miss), 0);
        end
        exp_score += 1;
        exp_combo = 2;
        exp_max   = 2;
        chk_counts("edge660");

        // 130 consecutive hits then a miss: combo saturates, max holds
        do_restart();
        for (int i = 1; i <= 130; i++) begin
            press_block(560);
            chk($sformatf("combo run %0d hit", i), int'(hit), 1);
            chk($sformatf("combo run %0d combo", i), int'(combo), (i > 127) ? 127 : i);
            chk($sformatf("combo run %0d score", i), int'(score), i);
        end
        step(100, 0);
        step(600, 0);
        step(661, 0);
        chk("combo run miss", int'(miss), 1);
        exp_score = 130;
        exp_combo = 0;
        exp_max   = 127;
        chk_counts("combo run end");

        // freeze for 50 cycles with key pressed in WINDOW
        do_restart();
        press_block(560);
        chk("frz pre hit", int'(hit), 1);
        step(100, 0);
        step(560, 0);
        stop_or_endgame = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step(570, 1);
            chk("frz hit", int'(hit), 0);
            chk("frz miss", int'(miss), 0);
            chk("frz perfect", int'(perfect), 0);
        end
        exp_score = 1;
        exp_combo = 1;
        exp_max   = 1;
        chk_counts("frz");
        stop_or_endgame = 1'b0;
        for (int h = 571; h <= 573; h++) begin
            step(h, 1);
            chk("unfrz held key hit", int'(hit), 0);
            chk("unfrz held key miss", int'(miss), 0);
        end
        step(574, 0);
        step(575, 0);
        step(576, 1);
        step(577, 1);
        step(578, 1);
        chk("unfrz fresh press hit", int'(hit), 1);
        exp_score = 2;
        exp_combo = 2;
        exp_max   = 2;
        chk_counts("unfrz");

        // restart in the middle of WINDOW
        step(100, 0);
        step(560, 0);
        restart = 1'b1;
        step(600, 1);
        restart = 1'b0;
        chk("restart hit", int'(hit), 0);
        chk("restart miss", int'(miss), 0);
        chk("restart perfect", int'(perfect), 0);
        chk("restart block_clear", int'(block_clear), 0);
        chk("restart score", int'(score), 0);
        chk("restart combo", int'(combo), 0);
        chk("restart max_combo", int'(max_combo), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lane_judge.md
LANE_JUDGE -- requirements
Module: lane_judge

Interface
REQ-001 SHALL have parameter WIN_LO, default 540: lowest block_h inside the hit window, inclusive.
REQ-002 SHALL have parameter WIN_HI, default 660: highest block_h inside the hit window, inclusive.
REQ-003 SHALL have parameter SCORE_MAX, default 999: score saturation value.
REQ-004 SHALL have port clk  input  1: clock, the same tick that advances block_h; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port restart  input  1: synchronous clear, active-high, same effect as rst.
REQ-007 SHALL have port stop_or_endgame  input  1: freeze; while high the FSM, counters and pulse outputs hold at idle.
REQ-008 SHALL have port block_h  input  10: vertical position of this lane's falling block from the block generator.
REQ-009 SHALL have port key_in  input  1: raw, asynchronous player key for this lane.
REQ-010 SHALL have port hit  output  1: one-cycle pulse for a successful press.
REQ-011 SHALL have port miss  output  1: one-cycle pulse for a missed block.
REQ-012 SHALL have port perfect  output  1: one-cycle pulse for a perfect press; it is coincident with hit.
REQ-013 SHALL have port block_clear  output  1: level signal, high from a hit until the next new block; the display uses it to hide the block.
REQ-014 SHALL have port score  output  10: accumulated points.
REQ-015 SHALL have port combo  output  7: current run of consecutive hits.
REQ-016 SHALL have port max_combo  output  7: largest combo value reached since reset.

Function
REQ-017 key_in SHALL pass through a 2-flop synchronizer.
REQ-018 A rising-edge detector SHALL follow the synchronizer, so that key_in high first sampled at edge k makes hit high during the cycle after edge k+2.
REQ-019 A registered prev_h SHALL hold block_h from the previous cycle.
REQ-020 new_blk SHALL be defined as block_h < prev_h, i.e. the generator has respawned the block.
REQ-021 The FSM SHALL have three states: WAIT, WINDOW and DONE.
REQ-022 WAIT -> WINDOW SHALL occur when WIN_LO <= block_h <= WIN_HI.
REQ-023 WINDOW -> DONE SHALL occur on a key edge while block_h is inside the window, giving a hit pulse and setting block_clear.
REQ-024 WINDOW -> DONE SHALL occur when block_h > WIN_HI with no key edge, giving a miss pulse.
REQ-025 A key edge and block_h = WIN_HI in the same cycle SHALL count as a hit.
REQ-026 DONE -> WAIT SHALL occur on new_blk, clearing block_clear.
REQ-027 new_blk while in WINDOW SHALL give a miss pulse and go to WAIT.
REQ-028 new_blk while in WAIT or DONE SHALL give no pulse and go to WAIT.
REQ-029 Key edges in WAIT or DONE SHALL be ignored, with no penalty.
REQ-030 Exactly one judgement, hit or miss, SHALL be made per block.
REQ-031 On hit, score SHALL add 1 and saturate at SCORE_MAX.
REQ-032 On hit, combo SHALL add 1 and saturate at 127.
REQ-033 max_combo SHALL update to combo's new value whenever that value exceeds max_combo.
REQ-034 On miss, combo SHALL reset to 0; score and max_combo SHALL be unchanged.
REQ-035 While stop_or_endgame is high, the state, prev_h, score and combo SHALL be held, and hit, miss and perfect SHALL be 0.
REQ-036 The synchronizer SHALL keep sampling while stop_or_endgame is high.
REQ-037 The edge detector SHALL consume any edge that occurs while frozen, so a key held across the unfreeze does not count as a press.
REQ-038 A block_h that saturates at 720 SHALL remain judged, with no repeat miss.

Reset
REQ-039 rst or restart SHALL set state = WAIT and prev_h = 0.
REQ-040 rst or restart SHALL clear the synchronizer and edge flops to 0.
REQ-041 rst or restart SHALL set hit = miss = perfect = block_clear = 0.
REQ-042 rst or restart SHALL set score = 0, combo = 0 and max_combo = 0.
REQ-043 rst or restart SHALL take effect at the next clock edge, override every other input, and apply identically in the middle of a judgement.

Configuration
REQ-044 With macro JUDGE_PERFECT_EN defined, a hit with 585 <= block_h <= 615 SHALL also pulse perfect and add 2 to score, saturating at SCORE_MAX.
REQ-045 Without JUDGE_PERFECT_EN, perfect SHALL be tied to 0 and every hit SHALL add 1.

Verification
REQ-046 The bench SHALL drive block_h ramping 500->700, with key_in rising when block_h = 598 -> one hit, score 1 (2 if JUDGE_PERFECT_EN), perfect per the macro, combo 1, block_clear high until the next new block.
REQ-047 The bench SHALL ramp block_h to 720 with no key -> miss pulse exactly when block_h = 661, combo 0, and no further miss while block_h holds at 720.
REQ-048 The bench SHALL press the key at block_h = 500, then at block_h = 560 -> the first press is ignored, the second gives a hit.
REQ-049 The bench SHALL drop block_h from 600 to 120 while in WINDOW with no press -> miss, state WAIT, then a normal hit on the next block.
REQ-050 The bench SHALL give 130 consecutive hits, then one miss -> combo saturates at 127 then goes to 0, max_combo stays 127, score reaches 130.
REQ-051 The bench SHALL hold stop_or_endgame high for 50 cycles while a key is pressed in the window, then release it -> no pulses, counters unchanged; assert restart mid-WINDOW -> all outputs 0 on the next edge.
